// File: rtl/decode_stage_if.sv
// Fetch/regfile/execute bundle around the decode stage.
// The decode stage uses the slave view; the surrounding pipeline uses master.
interface decode_stage_if #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32
);
   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_instr;
   logic [PC_WIDTH-1:0] in_pc;
   logic [4:0]          rs1_addr;
   logic [4:0]          rs2_addr;
   logic [XLEN-1:0]     rs1_data;
   logic [XLEN-1:0]     rs2_data;
   logic                out_valid;
   logic                out_ready;
   logic [6:0]          out_opcode;
   logic [2:0]          out_funct3;
   logic [6:0]          out_funct7;
   logic [4:0]          out_rd_addr;
   logic                out_rd_we;
   logic                out_illegal;
   logic [PC_WIDTH-1:0] out_pc;
   logic [XLEN-1:0]     out_opd1;
   logic [XLEN-1:0]     out_opd2;
   logic [XLEN-1:0]     out_opd3;
   logic [XLEN-1:0]     out_opd4;

   modport slave (
      input  flush, in_valid, in_instr, in_pc,
      input  rs1_data, rs2_data, out_ready,
      output in_ready, rs1_addr, rs2_addr,
      output out_valid, out_opcode, out_funct3,
      output out_funct7, out_rd_addr, out_rd_we,
      output out_illegal, out_pc,
      output out_opd1, out_opd2, out_opd3, out_opd4
   );

   modport master (
      output flush, in_valid, in_instr, in_pc,
      output rs1_data, rs2_data, out_ready,
      input  in_ready, rs1_addr, rs2_addr,
      input  out_valid, out_opcode, out_funct3,
      input  out_funct7, out_rd_addr, out_rd_we,
      input  out_illegal, out_pc,
      input  out_opd1, out_opd2, out_opd3, out_opd4
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64-ready decode stage: regfile read, immediates, ALU operands.
// One output register with valid/ready backpressure, flush and illegal flag.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave b
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   function automatic logic [XLEN-1:0] sext(
      input logic [31:0] v
   );
      return XLEN'($signed(v));
   endfunction

   logic [31:0]     ins;
   logic [6:0]      opc;
   logic [XLEN-1:0] imm_i, imm_s, imm_b;
   logic [XLEN-1:0] imm_j, imm_u, pc_x;
   logic            use1, use2;
   logic            accept;
   logic            n_we, n_ill;
   logic [XLEN-1:0] n_o1, n_o2, n_o3, n_o4;

   assign ins   = b.in_instr;
   assign opc   = ins[6:0];
   assign pc_x  = XLEN'(b.in_pc);
   assign imm_i = sext({{20{ins[31]}}, ins[31:20]});
   assign imm_s = sext({{20{ins[31]}}, ins[31:25],
                        ins[11:7]});
   assign imm_b = sext({{19{ins[31]}}, ins[31], ins[7],
                        ins[30:25], ins[11:8], 1'b0});
   assign imm_j = sext({{11{ins[31]}}, ins[31],
                        ins[19:12], ins[20],
                        ins[30:21], 1'b0});
   assign imm_u = sext({ins[31:12], 12'b0});

   assign b.in_ready = !b.out_valid || b.out_ready;
   assign accept     = b.in_valid && b.in_ready
                       && !b.flush;

   // Register-file read ports depend only on the opcode.
   always_comb begin
      use1 = 1'b0;
      use2 = 1'b0;
      unique case (opc)
         OP_R, OP_S, OP_B: begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         OP_I, OP_LOAD, OP_JALR: use1 = 1'b1;
         default: ;
      endcase
   end

   assign b.rs1_addr = use1 ? ins[19:15] : 5'd0;
   assign b.rs2_addr = use2 ? ins[24:20] : 5'd0;

   // Operand selection and destination write enable per format.
   always_comb begin
      n_o1  = '0;
      n_o2  = '0;
      n_o3  = '0;
      n_o4  = '0;
      n_we  = 1'b0;
      n_ill = 1'b0;
      unique case (opc)
         OP_R: begin
            n_o1 = b.rs1_data;
            n_o2 = b.rs2_data;
            n_we = 1'b1;
         end
         OP_I, OP_LOAD, OP_JALR: begin
            n_o1 = b.rs1_data;
            n_o2 = imm_i;
            n_we = 1'b1;
         end
         OP_S: begin
            n_o1 = b.rs1_data;
            n_o2 = imm_s;
            n_o3 = b.rs2_data;
         end
         OP_B: begin
            n_o1 = pc_x;
            n_o2 = imm_b;
            n_o3 = b.rs1_data;
            n_o4 = b.rs2_data;
         end
         OP_JAL: begin
            n_o1 = pc_x;
            n_o2 = imm_j;
            n_we = 1'b1;
         end
         OP_LUI: begin
            n_o1 = imm_u;
            n_we = 1'b1;
         end
         OP_AUIPC: begin
            n_o1 = imm_u;
            n_o2 = pc_x;
            n_we = 1'b1;
         end
         default: n_ill = 1'b1;
      endcase
   end

   // Output register; flush wins over accept and drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b.out_valid   <= 1'b0;
         b.out_opcode  <= '0;
         b.out_funct3  <= '0;
         b.out_funct7  <= '0;
         b.out_rd_addr <= '0;
         b.out_rd_we   <= 1'b0;
         b.out_illegal <= 1'b0;
         b.out_pc      <= '0;
         b.out_opd1    <= '0;
         b.out_opd2    <= '0;
         b.out_opd3    <= '0;
         b.out_opd4    <= '0;
      end else if (b.flush) begin
         b.out_valid <= 1'b0;
      end else if (accept) begin
         b.out_valid   <= 1'b1;
         b.out_opcode  <= opc;
         b.out_funct3  <= ins[14:12];
         b.out_funct7  <= ins[31:25];
         b.out_rd_addr <= n_we ? ins[11:7] : 5'd0;
         b.out_rd_we   <= n_we;
         b.out_illegal <= n_ill;
         b.out_pc      <= b.in_pc;
         b.out_opd1    <= n_o1;
         b.out_opd2    <= n_o2;
         b.out_opd3    <= n_o3;
         b.out_opd4    <= n_o4;
      end else if (b.out_ready) begin
         b.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32), .PC_WIDTH(32)) b ();
   decode_stage_if #(.XLEN(64), .PC_WIDTH(32)) w ();

   decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .b(b)
   );
   decode_stage #(.XLEN(64), .PC_WIDTH(32)) dut64 (
      .clk(clk), .rst(rst), .b(w)
   );

   logic [31:0] regs [32];
   assign b.rs1_data  = regs[b.rs1_addr];
   assign b.rs2_data  = regs[b.rs2_addr];
   assign w.rs1_data  = '0;
   assign w.rs2_data  = '0;
   assign w.flush     = 1'b0;
   assign w.out_ready = 1'b1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      logic [31:0] pc;
      logic [63:0] o1;
      logic [63:0] o2;
      logic [63:0] o3;
      logic [63:0] o4;
   } exp_t;

   // Reference decode from the ISA field definitions.
   function automatic exp_t model(input logic [31:0] i,
                                  input logic [31:0] pc);
      exp_t e;
      longint si, r1, r2, p;
      longint im_i, im_s, im_b, im_j, im_u;
      si   = longint'($signed(i));
      r1   = longint'(regs[i[19:15]]);
      r2   = longint'(regs[i[24:20]]);
      p    = longint'(pc);
      im_i = si >>> 20;
      im_s = ((si >>> 25) <<< 5)
             | longint'(i[11:7]);
      im_b = ((si >>> 31) <<< 12)
             | (longint'(i[7]) << 11)
             | (longint'(i[30:25]) << 5)
             | (longint'(i[11:8]) << 1);
      im_j = ((si >>> 31) <<< 20)
             | (longint'(i[19:12]) << 12)
             | (longint'(i[20]) << 11)
             | (longint'(i[30:21]) << 1);
      im_u = (si >>> 12) <<< 12;
      e     = '0;
      e.opc = i[6:0];
      e.f3  = i[14:12];
      e.f7  = i[31:25];
      e.pc  = pc;
      e.we  = 1'b1;
      case (i[6:0])
         7'h33: begin
            e.o1 = r1; e.o2 = r2;
         end
         7'h13, 7'h03, 7'h67: begin
            e.o1 = r1; e.o2 = im_i;
         end
         7'h23: begin
            e.o1 = r1; e.o2 = im_s; e.o3 = r2;
            e.we = 1'b0;
         end
         7'h63: begin
            e.o1 = p; e.o2 = im_b;
            e.o3 = r1; e.o4 = r2;
            e.we = 1'b0;
         end
         7'h6f: begin
            e.o1 = p; e.o2 = im_j;
         end
         7'h37: e.o1 = im_u;
         7'h17: begin
            e.o1 = im_u; e.o2 = p;
         end
         default: begin
            e.ill = 1'b1;
            e.we  = 1'b0;
         end
      endcase
      e.rd = e.we ? i[11:7] : 5'd0;
      return e;
   endfunction

   function automatic logic [4:0] x_rs1(input logic [31:0] i);
      case (i[6:0])
         7'h33, 7'h13, 7'h03,
         7'h23, 7'h63, 7'h67: return i[19:15];
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] x_rs2(input logic [31:0] i);
      case (i[6:0])
         7'h33, 7'h23, 7'h63: return i[24:20];
         default: return 5'd0;
      endcase
   endfunction

   exp_t q[$];
   int   del [bit [31:0]];

   function automatic int dcount(input bit [31:0] pc);
      return del.exists(pc) ? del[pc] : 0;
   endfunction

   // Compare against the model, then advance it for the next edge.
   always @(negedge clk) begin : cmp
      exp_t e;
      bit   acc;
      if (rst) q.delete();
      chk("in_ready", b.in_ready,
          q.size() == 0 || b.out_ready);
      chk("out_valid", b.out_valid, q.size() != 0);
      chk("rs1_addr", b.rs1_addr, x_rs1(b.in_instr));
      chk("rs2_addr", b.rs2_addr, x_rs2(b.in_instr));
      if (q.size() != 0) begin
         e = q[0];
         chk("opcode", b.out_opcode, e.opc);
         chk("funct3", b.out_funct3, e.f3);
         chk("funct7", b.out_funct7, e.f7);
         chk("rd_addr", b.out_rd_addr, e.rd);
         chk("rd_we", b.out_rd_we, e.we);
         chk("illegal", b.out_illegal, e.ill);
         chk("pc", b.out_pc, e.pc);
         chk("opd1", b.out_opd1, e.o1[31:0]);
         chk("opd2", b.out_opd2, e.o2[31:0]);
         chk("opd3", b.out_opd3, e.o3[31:0]);
         chk("opd4", b.out_opd4, e.o4[31:0]);
      end
      if (!rst) begin
         if (b.out_valid && b.out_ready)
            del[b.out_pc] = dcount(b.out_pc) + 1;
         acc = b.in_valid && !b.flush
               && (q.size() == 0 || b.out_ready);
         if (b.flush) begin
            q.delete();
         end else begin
            if (q.size() != 0 && b.out_ready)
               void'(q.pop_front());
            if (acc)
               q.push_back(model(b.in_instr, b.in_pc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] i,
                          input logic [31:0] pc);
      b.in_valid = 1'b1;
      b.in_instr = i;
      b.in_pc    = pc;
   endtask

   logic [31:0] flow [8];
   logic [31:0] snap1, snap2;

   initial begin
      for (int k = 0; k < 32; k++) regs[k] = '0;
      b.flush     = 1'b0;
      b.in_valid  = 1'b0;
      b.in_instr  = '0;
      b.in_pc     = '0;
      b.out_ready = 1'b0;
      w.in_valid  = 1'b0;
      w.in_instr  = '0;
      w.in_pc     = '0;
      #1;
      chk("rst_valid", b.out_valid, 0);
      chk("rst_ready", b.in_ready, 1);
      chk("rst_opd1", b.out_opd1, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // ADDI x5,x1,-1
      regs[1] = 32'h10;
      b.out_ready = 1'b1;
      present(32'hFFF08293, 32'h40);
      #1 chk("addi_rs1a", b.rs1_addr, 1);
      step();
      b.in_valid = 1'b0;
      chk("addi_valid", b.out_valid, 1);
      chk("addi_opd1", b.out_opd1, 32'h10);
      chk("addi_opd2", b.out_opd2, 32'hFFFFFFFF);
      chk("addi_rd", b.out_rd_addr, 5);
      chk("addi_we", b.out_rd_we, 1);

      // BEQ x1,x2,-4
      regs[1] = 32'h7;
      regs[2] = 32'h7;
      present(32'hFE208EE3, 32'h100);
      step();
      b.in_valid = 1'b0;
      chk("beq_opd1", b.out_opd1, 32'h100);
      chk("beq_opd2", b.out_opd2, 32'hFFFFFFFC);
      chk("beq_opd3", b.out_opd3, 7);
      chk("beq_opd4", b.out_opd4, 7);
      chk("beq_we", b.out_rd_we, 0);
      chk("beq_rd", b.out_rd_addr, 0);

      // Back-to-back stream: no bubbles expected
      regs[1] = 32'h1000;
      regs[2] = 32'h55;
      flow[0] = 32'h002081B3;
      flow[1] = 32'h0020A423;
      flow[2] = 32'h010000EF;
      flow[3] = 32'h12345397;
      flow[4] = 32'hFF80A203;
      flow[5] = 32'h00008067;
      flow[6] = 32'hABCDE337;
      flow[7] = 32'h40208233;
      for (int k = 0; k < 8; k++) begin
         present(flow[k], 32'h300 + 32'(4 * k));
         step();
         chk("flow_valid", b.out_valid, 1);
         chk("flow_pc", b.out_pc, 32'h300 + 32'(4 * k));
      end
      b.in_valid = 1'b0;
      step();
      chk("sw_once", dcount(32'h304), 1);

      // Backpressure: hold LW, SW waits
      b.out_ready = 1'b0;
      present(32'hFF80A203, 32'h400);
      step();
      present(32'h0020A423, 32'h404);
      snap1 = b.out_opd1;
      snap2 = b.out_opd2;
      for (int k = 0; k < 3; k++) begin
         chk("bp_ready", b.in_ready, 0);
         chk("bp_pc", b.out_pc, 32'h400);
         chk("bp_opd1", b.out_opd1, snap1);
         chk("bp_opd2", b.out_opd2, snap2);
         step();
      end
      b.out_ready = 1'b1;
      step();
      b.in_valid = 1'b0;
      chk("bp_next_pc", b.out_pc, 32'h404);
      repeat (2) step();
      chk("bp_lw_once", dcount(32'h400), 1);
      chk("bp_sw_once", dcount(32'h404), 1);

      // Flush with held and incoming instruction
      b.out_ready = 1'b0;
      present(32'hFFF08293, 32'h500);
      step();
      present(32'hFE208EE3, 32'h504);
      b.flush = 1'b1;
      step();
      b.flush = 1'b0;
      b.in_valid = 1'b0;
      chk("fl_valid", b.out_valid, 0);
      b.out_ready = 1'b1;
      repeat (3) step();
      chk("fl_drop_a", dcount(32'h500), 0);
      chk("fl_drop_b", dcount(32'h504), 0);

      // Illegal opcode
      present(32'h0000007F, 32'h600);
      step();
      b.in_valid = 1'b0;
      chk("ill_valid", b.out_valid, 1);
      chk("ill_flag", b.out_illegal, 1);
      chk("ill_opc", b.out_opcode, 7'h7F);
      chk("ill_we", b.out_rd_we, 0);
      chk("ill_opd1", b.out_opd1, 0);
      chk("ill_opd2", b.out_opd2, 0);
      chk("ill_opd3", b.out_opd3, 0);
      chk("ill_opd4", b.out_opd4, 0);
      chk("ill_pc", b.out_pc, 32'h600);

      // XLEN=64 LUI x5,0x80000
      w.in_valid = 1'b1;
      w.in_instr = 32'h800002B7;
      w.in_pc    = 32'h700;
      step();
      w.in_valid = 1'b0;
      chk("w_valid", w.out_valid, 1);
      chk("w_opd1", w.out_opd1, 64'hFFFFFFFF80000000);
      chk("w_opd2", w.out_opd2, 0);
      chk("w_rd", w.out_rd_addr, 5);
      chk("w_we", w.out_rd_we, 1);

      // Async reset while a bundle is stalled
      b.out_ready = 1'b0;
      present(32'hFFF08293, 32'h800);
      step();
      b.in_valid = 1'b0;
      chk("ar_pre", b.out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", b.out_valid, 0);
      chk("ar_pc", b.out_pc, 0);
      chk("ar_opd1", b.out_opd1, 0);
      chk("ar_we", b.out_rd_we, 0);
      chk("ar_w_valid", w.out_valid, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("ar_ready", b.in_ready, 1);
      chk("ar_after", b.out_valid, 0);
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64-ready instruction decode pipeline stage between fetch and the ALU/execute stage.
- Accepts a fetched instruction and PC over a valid/ready handshake, reads the register file, and forms sign-extended immediates and the four ALU operands.
- Latches the decoded bundle into an output register with valid/ready backpressure, flush, and an illegal-opcode flag.

Parameters:
- XLEN, 32, datapath/operand width; ≥ 32; immediates sign-extended to XLEN.
- PC_WIDTH, 32, program-counter width; ≤ XLEN; zero-extended when placed on an operand.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard held and incoming instruction.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_WIDTH  PC of in_instr.
- rs1_addr  out  5  register-file read address 1, combinational from in_instr.
- rs2_addr  out  5  register-file read address 2, combinational from in_instr.
- rs1_data  in  XLEN  combinational read data for rs1_addr.
- rs2_data  in  XLEN  combinational read data for rs2_addr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_opcode  out  7  opcode.
- out_funct3  out  3  funct3.
- out_funct7  out  7  funct7.
- out_rd_addr  out  5  destination register.
- out_rd_we  out  1  destination write enable.
- out_illegal  out  1  unsupported opcode.
- out_pc  out  PC_WIDTH  PC of the bundle.
- out_opd1 / out_opd2 / out_opd3 / out_opd4  out  XLEN each  ALU operands.

Behaviour:
- Reset: out_valid=0; every out_* payload = 0. in_ready=1 after reset.
- in_ready = !out_valid || out_ready (combinational). Accept happens when in_valid && in_ready && !flush.
- Accept: the bundle is registered on that edge, so out_valid rises one cycle after acceptance (latency 1). No bubble under continuous flow.
- Register update: out_valid is set on accept, cleared on (out_ready && !accept), and held otherwise. While out_valid && !out_ready, all out_* stay bit-stable.
- Flush: on the next edge out_valid=0. The incoming instruction in that cycle is dropped. Flush takes priority over accept and out_ready; payload may hold stale values.
- rs1_addr = instr[19:15] for R/I/LOAD/S/B/JALR, else 0.
- rs2_addr = instr[24:20] for R/S/B, else 0.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U = {instr[31:12], 12'b0}.
- Operand map (opd1, opd2, opd3, opd4); unlisted operands are 0:
  - R (0110011): rs1, rs2.
  - I (0010011), LOAD (0000011), JALR (1100111): rs1, immI.
  - S (0100011): rs1, immS, rs2 (store data).
  - B (1100011): pc, immB, rs1, rs2.
  - JAL (1101111): pc, immJ.
  - LUI (0110111): immU, 0.
  - AUIPC (0010111): immU, pc.
- out_rd_we = 1 for R/I/LOAD/JAL/JALR/LUI/AUIPC, and 0 for S/B/illegal. out_rd_addr = instr[11:7] when rd_we=1, else 0.
- Illegal opcode: the bundle is still delivered with out_valid=1, out_illegal=1, all operands 0, rd_we=0, opcode/funct/pc passed through. No simulation error is raised.
- Register x0 is not special-cased here; the register file returns 0.
- Reset asserted mid-stream clears out_valid immediately (asynchronously), regardless of out_ready.

Test Plan:
- Reset: assert rst mid-transfer with out_valid=1 → out_valid=0 immediately, all payload 0, in_ready=1 after release.
- ADDI x5,x1,-1 (0xFFF08293), rs1_data=0x10, pc=0x40 → next cycle out_valid=1, opd1=0x10, opd2=0xFFFFFFFF, rd_addr=5, rd_we=1, rs1_addr=1 while presented.
- BEQ x1,x2,-4 (0xFE208EE3), pc=0x100, rs1_data=7, rs2_data=7 → opd1=0x100, opd2=0xFFFFFFFC, opd3=7, opd4=7, rd_we=0, rd_addr=0.
- Backpressure: bundle valid, out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs bit-stable, second instruction delivered exactly once after out_ready=1.
- Flush with in_valid=1 and out_valid=1 same cycle → next cycle out_valid=0, neither instruction appears at output.
- Illegal 0x0000007F → out_valid=1, out_illegal=1, opd1..4=0, rd_we=0, out_opcode=0x7F; repeat with XLEN=64 LUI 0x800002B7 → opd1=0xFFFFFFFF80000000.
